drive_cmd_arbiter: RTL

DRIVE_CMD_ARBITER -- requirements
Module: drive_cmd_arbiter

---
 rtl/drive_cmd_arbiter.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/drive_cmd_arbiter.sv
// Motion command arbiter: decodes IR/UART keys, ramps the shared motor duty and stops on obstacles.
// Build option DRIVE_TIMEOUT_EN adds a command-silence brake while driving.
module drive_cmd_arbiter #(
  parameter int DUTY_MAX         = 20,
  parameter int RAMP_STEP_CYCLES = 500_000,
  parameter int TIMEOUT_CYCLES   = 50_000_000,
  parameter int PROX_STOP        = 12
) (
  input  logic       clk,
  input  logic       iRST_n,
  input  logic       ir_valid,
  input  logic [7:0] ir_code,
  input  logic       uart_valid,
  input  logic [7:0] uart_byte,
  input  logic [3:0] prox_level,
  output logic [2:0] motor_stat,
  output logic [6:0] duty,
  output logic       blocked,
  output logic [7:0] stat_byte,
  output logic       stat_valid
);

  localparam logic [2:0] CMD_NONE  = 3'd0;
  localparam logic [2:0] CMD_FWD   = 3'd1;
  localparam logic [2:0] CMD_LEFT  = 3'd2;
  localparam logic [2:0] CMD_BRAKE = 3'd3;
  localparam logic [2:0] CMD_RIGHT = 3'd4;
  localparam logic [2:0] CMD_BACK  = 3'd5;

  localparam int                STEP_W    = (RAMP_STEP_CYCLES > 1) ? $clog2(RAMP_STEP_CYCLES) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(RAMP_STEP_CYCLES - 1);
  localparam logic [6:0]        DUTY_TOP  = 7'(DUTY_MAX);
  localparam logic [4:0]        PROX_HI   = 5'(PROX_STOP);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_RUN       = 3'd2,
    ST_RAMP_DOWN = 3'd3,
    ST_BLOCKED   = 3'd4
  } state_t;

  state_t            r_state;
  logic [2:0]        r_motor_stat;
  logic [6:0]        r_duty;
  logic              r_blocked;
  logic              r_pend_vld;
  logic [2:0]        r_pend;
  logic [STEP_W-1:0] r_step;
  logic [3:0]        r_stat_prev;
  logic              r_stat_valid;

  logic [2:0] w_cmd;
  logic       w_cmd_vld;
  logic       w_brake;
  logic       w_obstacle;
  logic       w_clear;
  logic       w_step_done;
  logic       w_timeout;
  logic       w_pend_vld_n;
  logic [2:0] w_pend_n;

  function automatic logic [2:0] dec_ir(input logic [7:0] code);
    case (code)
      8'h02:   dec_ir = CMD_FWD;
      8'h04:   dec_ir = CMD_LEFT;
      8'h05:   dec_ir = CMD_BRAKE;
      8'h06:   dec_ir = CMD_RIGHT;
      8'h08:   dec_ir = CMD_BACK;
      default: dec_ir = CMD_NONE;
    endcase
  endfunction

  function automatic logic [2:0] dec_uart(input logic [7:0] code);
    case (code)
      8'h77:   dec_uart = CMD_FWD;
      8'h61:   dec_uart = CMD_LEFT;
      8'h20:   dec_uart = CMD_BRAKE;
      8'h64:   dec_uart = CMD_RIGHT;
      8'h73:   dec_uart = CMD_BACK;
      default: dec_uart = CMD_NONE;
    endcase
  endfunction

  // Source select (a UART strobe always masks IR) and per-cycle condition flags
  always_comb begin
    w_cmd = CMD_NONE;
    if (uart_valid) begin
      w_cmd = dec_uart(uart_byte);
    end else if (ir_valid) begin
      w_cmd = dec_ir(ir_code);
    end else begin
      w_cmd = CMD_NONE;
    end
    w_cmd_vld   = (w_cmd != CMD_NONE);
    w_brake     = (w_cmd == CMD_BRAKE);
    w_obstacle  = (r_state != ST_BLOCKED) && (r_motor_stat == CMD_FWD) &&
                  ({1'b0, prox_level} >= PROX_HI);
    w_clear     = (({1'b0, prox_level} + 5'd2) <= PROX_HI);
    w_step_done = (r_step == STEP_LAST);
  end

  // Pending command as seen after this cycle's command during a ramp-down
  always_comb begin
    w_pend_vld_n = r_pend_vld;
    w_pend_n     = r_pend;
    if (w_brake) begin
      w_pend_vld_n = 1'b0;
    end else if (w_cmd_vld) begin
      w_pend_vld_n = 1'b1;
      w_pend_n     = w_cmd;
    end else begin
      w_pend_n     = r_pend;
    end
  end

`ifdef DRIVE_TIMEOUT_EN
  localparam int SIL_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [SIL_W-1:0] r_silence;
  logic             w_active;

  assign w_active  = (r_state == ST_RAMP_UP) || (r_state == ST_RUN);
  assign w_timeout = w_active && !w_cmd_vld && (r_silence == SIL_W'(TIMEOUT_CYCLES - 1));

  // Silence counter: only runs while driving, any recognised command restarts it
  always_ff @(posedge clk or negedge iRST_n) begin
    if (!iRST_n) begin
      r_silence <= {SIL_W{1'b0}};
    end else if (!w_active || w_cmd_vld || w_timeout) begin
      r_silence <= {SIL_W{1'b0}};
    end else begin
      r_silence <= r_silence + SIL_W'(1);
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Main FSM; the obstacle stop outranks any command in the same cycle
  always_ff @(posedge clk or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state      <= ST_IDLE;
      r_motor_stat <= CMD_NONE;
      r_duty       <= 7'd0;
      r_blocked    <= 1'b0;
      r_pend_vld   <= 1'b0;
      r_pend       <= CMD_NONE;
      r_step       <= {STEP_W{1'b0}};
      r_stat_prev  <= 4'd0;
      r_stat_valid <= 1'b0;
    end else begin
      r_stat_prev  <= {r_motor_stat, r_blocked};
      r_stat_valid <= ({r_motor_stat, r_blocked} != r_stat_prev);
      if (w_obstacle) begin
        r_state      <= ST_BLOCKED;
        r_duty       <= 7'd0;
        r_motor_stat <= CMD_BRAKE;
        r_blocked    <= 1'b1;
        r_pend_vld   <= 1'b0;
        r_step       <= {STEP_W{1'b0}};
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_brake) begin
              r_motor_stat <= CMD_BRAKE;
            end else if (w_cmd_vld) begin
              r_motor_stat <= w_cmd;
              r_state      <= ST_RAMP_UP;
              r_step       <= {STEP_W{1'b0}};
            end
          end
          ST_RAMP_UP, ST_RUN: begin
            if (w_brake || w_timeout) begin
              r_motor_stat <= CMD_BRAKE;
              r_pend_vld   <= 1'b0;
              r_step       <= {STEP_W{1'b0}};
              r_state      <= (r_duty == 7'd0) ? ST_IDLE : ST_RAMP_DOWN;
            end else if (w_cmd_vld && (w_cmd != r_motor_stat)) begin
              r_pend       <= w_cmd;
              r_pend_vld   <= 1'b1;
              r_state      <= ST_RAMP_DOWN;
              r_step       <= {STEP_W{1'b0}};
            end else if (r_state == ST_RAMP_UP) begin
              if (r_duty >= DUTY_TOP) begin
                r_state <= ST_RUN;
                r_step  <= {STEP_W{1'b0}};
              end else if (w_step_done) begin
                r_step <= {STEP_W{1'b0}};
                r_duty <= r_duty + 7'd1;
                if ((r_duty + 7'd1) >= DUTY_TOP) begin
                  r_state <= ST_RUN;
                end
              end else begin
                r_step <= r_step + STEP_W'(1);
              end
            end
          end
          ST_RAMP_DOWN: begin
            if (w_brake) begin
              r_motor_stat <= CMD_BRAKE;
            end
            r_pend_vld <= w_pend_vld_n;
            r_pend     <= w_pend_n;
            // Reaching zero hands over to the pending command, if any survived this cycle
            if ((r_duty == 7'd0) || (w_step_done && (r_duty == 7'd1))) begin
              r_duty <= 7'd0;
              r_step <= {STEP_W{1'b0}};
              if (w_pend_vld_n) begin
                r_motor_stat <= w_pend_n;
                r_pend_vld   <= 1'b0;
                r_state      <= ST_RAMP_UP;
              end else begin
                r_motor_stat <= CMD_NONE;
                r_state      <= ST_IDLE;
              end
            end else if (w_step_done) begin
              r_step <= {STEP_W{1'b0}};
              r_duty <= r_duty - 7'd1;
            end else begin
              r_step <= r_step + STEP_W'(1);
            end
          end
          ST_BLOCKED: begin
            if (w_brake) begin
              r_motor_stat <= CMD_BRAKE;
              r_blocked    <= 1'b0;
              r_state      <= ST_IDLE;
            end else if ((w_cmd == CMD_LEFT) || (w_cmd == CMD_RIGHT) || (w_cmd == CMD_BACK)) begin
              r_motor_stat <= w_cmd;
              r_blocked    <= 1'b0;
              r_state      <= ST_RAMP_UP;
              r_step       <= {STEP_W{1'b0}};
            end else if (w_clear) begin
              r_motor_stat <= CMD_NONE;
              r_blocked    <= 1'b0;
              r_state      <= ST_IDLE;
            end
          end
          default: begin
            r_state      <= ST_IDLE;
            r_motor_stat <= CMD_NONE;
            r_duty       <= 7'd0;
            r_blocked    <= 1'b0;
            r_pend_vld   <= 1'b0;
            r_step       <= {STEP_W{1'b0}};
          end
        endcase
      end
    end
  end

  assign motor_stat = r_motor_stat;
  assign duty       = r_duty;
  assign blocked    = r_blocked;
  assign stat_valid = r_stat_valid;
  // Combinational so the live proximity level is visible even while held in reset
  assign stat_byte  = {prox_level, r_motor_stat, 1'b1};

endmodule
